beh_reset_seq: RTL and testbench

- Clocked, synthesizable successor to the behavioural reset/start generator used by csp2verilog testbenches.
- Produces the same packed active-low control vector: resets, starts, steps, delays, captures, cutscans.
- Release timing is counted in clock cycles, not `#` delays.
- Adds: per-bit delay configuration from a port, optional one-at-a-time step release, live cutscan control, and re-runnable sequencing via a restart request.

---
 rtl/beh_reset_seq.sv | 157 +++++++++++++++
 tb/tb_beh_reset_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/beh_reset_seq.sv
// Clocked reset/start sequencer: drives a packed active-low control vector
// (resets, starts, steps, delays, captures, cutscans; LSB first) and releases
// each group after a configurable number of clock edges.
module beh_reset_seq #(
    parameter int RESETS       = 1,
    parameter int STARTS       = 0,
    parameter int STEPS        = 0,
    parameter int DELAYS       = 0,
    parameter int CAPTURES     = 0,
    parameter int CUTSCANS     = 0,
    parameter int RESET_CYCLES = 10,
    parameter int START_CYCLES = 10,
    parameter int STEP_MODE    = 0,
    localparam int N  = RESETS + STARTS + STEPS + DELAYS + CAPTURES + CUTSCANS,
    localparam int DW = (DELAYS > 0) ? DELAYS : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    input  logic [DW-1:0] dly_cfg,
    input  logic          step_req,
    input  logic          cutscan_en,
    output logic [N-1:0]  reset_n,
    output logic          done
);

    localparam int MAXC = (RESET_CYCLES > START_CYCLES) ? RESET_CYCLES : START_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int SW   = (STEPS > 0) ? $clog2(STEPS + 1) : 1;

    localparam int unsigned OFF_RST = 0;
    localparam int unsigned OFF_STA = OFF_RST + RESETS;
    localparam int unsigned OFF_STP = OFF_STA + STARTS;
    localparam int unsigned OFF_DLY = OFF_STP + STEPS;
    localparam int unsigned OFF_CAP = OFF_DLY + DELAYS;
    localparam int unsigned OFF_CUT = OFF_CAP + CAPTURES;

    localparam bit HAS_WAIT = (STARTS + STEPS + CAPTURES) > 0;

    // Group masks keep empty groups free of any index arithmetic on the vector.
    function automatic logic [N-1:0] grp_mask(input int unsigned lo, input int unsigned cnt);
        logic [N-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < N; i++) begin
            m[i] = ((i - lo) < cnt);
        end
        return m;
    endfunction

    localparam logic [N-1:0] RST_MASK = grp_mask(OFF_RST, RESETS);
    localparam logic [N-1:0] STA_MASK = grp_mask(OFF_STA, STARTS);
    localparam logic [N-1:0] STP_MASK = grp_mask(OFF_STP, STEPS);
    localparam logic [N-1:0] DLY_MASK = grp_mask(OFF_DLY, DELAYS);
    localparam logic [N-1:0] CAP_MASK = grp_mask(OFF_CAP, CAPTURES);
    localparam logic [N-1:0] CUT_MASK = grp_mask(OFF_CUT, CUTSCANS);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_WAIT_START,
        ST_STEPPING,
        ST_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] sidx;
    logic          load;
    logic [N-1:0]  dly_vec;
    logic [N-1:0]  step_bit;
    logic [N-1:0]  base;

    // Placement of the delay config and the next step bit; base folds in the
    // one-shot post-reset delay load so every state update starts from it.
    always_comb begin
        dly_vec  = (N'(dly_cfg) << OFF_DLY) & DLY_MASK;
        step_bit = (N'(1) << (OFF_STP + sidx)) & STP_MASK;
        base     = load ? ((reset_n & ~DLY_MASK) | dly_vec) : reset_n;
    end

    // Sequencer FSM with registered control vector and done flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_ASSERT;
            cnt     <= '0;
            sidx    <= '0;
            done    <= 1'b0;
            reset_n <= '0;
            load    <= 1'b1;
        end else if (restart) begin
            state   <= ST_ASSERT;
            cnt     <= '0;
            sidx    <= '0;
            done    <= 1'b0;
            reset_n <= dly_vec;
            load    <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state)
                ST_ASSERT: begin
                    if (cnt == CW'(RESET_CYCLES - 1)) begin
                        cnt     <= '0;
                        reset_n <= base | RST_MASK;
                        if (HAS_WAIT) begin
                            state <= ST_WAIT_START;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt     <= cnt + 1'b1;
                        reset_n <= base;
                    end
                end
                ST_WAIT_START: begin
                    if (cnt == CW'(START_CYCLES - 1)) begin
                        cnt <= '0;
                        if (STEP_MODE == 0) begin
                            reset_n <= base | STA_MASK | CAP_MASK | STP_MASK;
                            state   <= ST_DONE;
                            done    <= 1'b1;
                        end else if (STEPS > 0) begin
                            reset_n <= base | STA_MASK | CAP_MASK;
                            state   <= ST_STEPPING;
                        end else begin
                            reset_n <= base | STA_MASK | CAP_MASK;
                            state   <= ST_DONE;
                            done    <= 1'b1;
                        end
                    end else begin
                        cnt     <= cnt + 1'b1;
                        reset_n <= base;
                    end
                end
                ST_STEPPING: begin
                    if (step_req) begin
                        reset_n <= base | step_bit;
                        sidx    <= sidx + 1'b1;
                        if (sidx == SW'(STEPS - 1)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        reset_n <= base;
                    end
                end
                ST_DONE: begin
                    reset_n <= (base & ~CUT_MASK) | (cutscan_en ? CUT_MASK : '0);
                end
                default: begin
                    state   <= ST_ASSERT;
                    reset_n <= base;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beh_reset_seq.sv
// Bench for beh_reset_seq: directed scenarios plus randomized inputs, checked
// against a timeline model (edges since sequence entry, steps taken).
module tb_beh_reset_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       restart0 = 1'b0;
    logic       restart1 = 1'b0;
    logic       step_req = 1'b0;
    logic       cutscan_en = 1'b0;
    logic       dly_cfg = 1'b1;
    logic       zero = 1'b0;
    logic [6:0] v0, v1;
    logic [1:0] v2;
    logic       d0, d1, d2;

    int checks = 0;
    int errors = 0;

    // model state per common-config instance (0: STEP_MODE=0, 1: STEP_MODE=1)
    int   t[2];
    int   k[2];
    logic dlyq[2];
    logic cut[2];
    logic ld[2];
    int   t2;

    always #5 clk = ~clk;

    beh_reset_seq #(.RESETS(1), .STARTS(1), .STEPS(2), .DELAYS(1), .CAPTURES(1),
                    .CUTSCANS(1), .RESET_CYCLES(4), .START_CYCLES(3), .STEP_MODE(0)) u0 (
        .clk(clk), .reset(reset), .restart(restart0), .dly_cfg(dly_cfg),
        .step_req(step_req), .cutscan_en(cutscan_en), .reset_n(v0), .done(d0));

    beh_reset_seq #(.RESETS(1), .STARTS(1), .STEPS(2), .DELAYS(1), .CAPTURES(1),
                    .CUTSCANS(1), .RESET_CYCLES(4), .START_CYCLES(3), .STEP_MODE(1)) u1 (
        .clk(clk), .reset(reset), .restart(restart1), .dly_cfg(dly_cfg),
        .step_req(step_req), .cutscan_en(cutscan_en), .reset_n(v1), .done(d1));

    beh_reset_seq #(.RESETS(2), .STARTS(0), .STEPS(0), .DELAYS(0), .CAPTURES(0),
                    .CUTSCANS(0), .RESET_CYCLES(1), .START_CYCLES(1), .STEP_MODE(0)) u2 (
        .clk(clk), .reset(reset), .restart(zero), .dly_cfg(dly_cfg),
        .step_req(step_req), .cutscan_en(cutscan_en), .reset_n(v2), .done(d2));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic mdone(input int unsigned m);
        return (t[m] >= 7) && ((m == 0) || (k[m] == 2));
    endfunction

    function automatic logic [6:0] mexp(input int unsigned m);
        logic [6:0] v;
        v    = '0;
        v[0] = (t[m] >= 4);
        v[1] = (t[m] >= 7);
        if (m == 0) begin
            v[2] = (t[m] >= 7);
            v[3] = (t[m] >= 7);
        end else begin
            v[2] = (k[m] >= 1);
            v[3] = (k[m] >= 2);
        end
        v[4] = dlyq[m];
        v[5] = (t[m] >= 7);
        v[6] = cut[m];
        return v;
    endfunction

    task automatic model_reset();
        for (int unsigned m = 0; m < 2; m++) begin
            t[m] = 0; k[m] = 0; dlyq[m] = 1'b0; cut[m] = 1'b0; ld[m] = 1'b1;
        end
        t2 = 0;
    endtask

    task automatic model_edge();
        logic rs[2];
        rs[0] = restart0;
        rs[1] = restart1;
        for (int unsigned m = 0; m < 2; m++) begin
            if (rs[m]) begin
                t[m] = 0; k[m] = 0; dlyq[m] = dly_cfg; cut[m] = 1'b0; ld[m] = 1'b0;
            end else begin
                cut[m] = mdone(m) ? cutscan_en : 1'b0;
                if (ld[m]) begin
                    dlyq[m] = dly_cfg;
                    ld[m]   = 1'b0;
                end
                if (m == 1 && t[m] >= 7 && k[m] < 2 && step_req) k[m]++;
                if (t[m] < 1000) t[m]++;
            end
        end
        if (t2 < 1000) t2++;
    endtask

    task automatic check_all();
        chk("u0_vec", {1'b0, v0}, {1'b0, mexp(0)});
        chk("u0_done", {7'b0, d0}, {7'b0, mdone(0)});
        chk("u1_vec", {1'b0, v1}, {1'b0, mexp(1)});
        chk("u1_done", {7'b0, d1}, {7'b0, mdone(1)});
        chk("u2_vec", {6'b0, v2}, (t2 >= 1) ? 8'h03 : 8'h00);
        chk("u2_done", {7'b0, d2}, {7'b0, (t2 >= 1)});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        check_all();
        chk("rst_u0_const", {1'b0, v0}, 8'h00);
        reset = 1'b0;

        // scenario 1/2: first pass, step_req during ASSERT is ignored
        tick();
        chk("e1_u0", {1'b0, v0}, 8'b00010000);
        chk("e1_u2", {6'b0, v2}, 8'h03);
        step_req = 1'b1;
        tick(); tick();
        step_req = 1'b0;
        chk("e3_u0", {1'b0, v0}, 8'b00010000);
        chk("e3_u1", {1'b0, v1}, 8'b00010000);
        tick();
        chk("e4_u0", {1'b0, v0}, 8'b00010001);
        tick(); tick(); tick();
        chk("e7_u0", {1'b0, v0}, 8'b00111111);
        chk("e7_u0_done", {7'b0, d0}, 8'h01);
        chk("e7_u1", {1'b0, v1}, 8'b00110011);
        chk("e7_u1_done", {7'b0, d1}, 8'h00);
        cutscan_en = 1'b1;
        tick();
        chk("cut_u0", {1'b0, v0}, 8'b01111111);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step1_u1", {1'b0, v1}, 8'b00110111);
        tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step2_u1", {1'b0, v1}, 8'b00111111);
        chk("step2_u1_done", {7'b0, d1}, 8'h01);
        tick();
        chk("cut_u1", {1'b0, v1}, 8'b01111111);

        // scenario 3: restart from DONE with new delay config, held two edges
        cutscan_en = 1'b0;
        dly_cfg    = 1'b0;
        restart0   = 1'b1;
        tick();
        chk("rs_u0", {1'b0, v0}, 8'h00);
        chk("rs_u0_done", {7'b0, d0}, 8'h00);
        tick();
        restart0 = 1'b0;
        tick(); tick(); tick();
        chk("rs_e3_u0", {1'b0, v0}, 8'h00);
        tick();
        chk("rs_e4_u0", {1'b0, v0}, 8'b00000001);
        tick(); tick(); tick();
        chk("rs_e7_u0", {1'b0, v0}, 8'b00101111);
        chk("rs_e7_u0_done", {7'b0, d0}, 8'h01);

        // scenario 4: restart beats step_req in STEPPING
        restart1 = 1'b1;
        tick();
        restart1 = 1'b0;
        repeat (7) tick();
        chk("stp_u1", {1'b0, v1}, 8'b00100011);
        restart1 = 1'b1;
        step_req = 1'b1;
        tick();
        restart1 = 1'b0;
        step_req = 1'b0;
        chk("rs_vs_step_u1", {1'b0, v1}, 8'h00);
        repeat (7) tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("sidx0_u1", {1'b0, v1}, 8'b00100111);

        // scenario 5: async reset mid-sequence
        dly_cfg = 1'b1;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        reset = 1'b0;
        repeat (5) tick();
        chk("ar_e5_u0", {1'b0, v0}, 8'b00010001);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("ar_mid_u0", {1'b0, v0}, 8'h00);
        reset = 1'b0;
        repeat (3) tick();
        chk("ar_re3_u0", {1'b0, v0}, 8'b00010000);
        tick();
        chk("ar_re4_u0", {1'b0, v0}, 8'b00010001);

        // randomized run against the timeline model
        for (int unsigned i = 0; i < 400; i++) begin
            step_req   = (($urandom % 3) == 0);
            cutscan_en = 1'($urandom % 2);
            dly_cfg    = 1'($urandom % 2);
            restart0   = (($urandom % 40) == 0);
            restart1   = (($urandom % 40) == 0);
            if (i == 200) begin
                reset = 1'b1;
                model_reset();
                #1;
                check_all();
                reset = 1'b0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
